// File: rtl/decap_stream_shift.sv
// Removes one byte region (offset + length) from a sliced packet stream and
// re-packs the surviving bytes into dense slices with regenerated tags.
module decap_stream_shift #(
  parameter int unsigned SLICE_BYTES = 16,
  parameter int unsigned OFS_W       = 8,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned CNT_W       = 12
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  input  logic                           i_start,
  input  logic                           i_tail,
  input  logic [SLICE_BYTES*8-1:0]       i_data,
  input  logic [$clog2(SLICE_BYTES):0]   i_last_bytes,
  input  logic [OFS_W-1:0]               i_decap_ofs,
  input  logic [LEN_W-1:0]               i_decap_len,
  output logic                           o_in_ready,
  output logic                           o_valid,
  output logic                           o_start,
  output logic                           o_tail,
  output logic [SLICE_BYTES*8-1:0]       o_data,
  output logic [$clog2(SLICE_BYTES):0]   o_last_bytes,
  output logic                           o_err,
  output logic                           o_drop
);

  localparam int unsigned DW        = SLICE_BYTES * 8;
  localparam int unsigned LB_W      = $clog2(SLICE_BYTES) + 1;
  localparam int unsigned BUF_BYTES = 2 * SLICE_BYTES;
  localparam int unsigned IDX_W     = $clog2(BUF_BYTES);
  localparam int unsigned FILL_W    = IDX_W + 1;
  localparam int unsigned END_W     = ((OFS_W > LEN_W) ? OFS_W : LEN_W) + 1;
  localparam int unsigned POS_W     = CNT_W + 1;
  localparam int unsigned CMP_W     = (POS_W > END_W) ? POS_W : END_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, PRE, SKIP, POST, FLUSH} state_t;

  state_t                state_q;
  logic [7:0]            pack_q [BUF_BYTES];
  logic [FILL_W-1:0]     fill_q;
  logic [CNT_W-1:0]      pos_q;
  logic [OFS_W-1:0]      ofs_q;
  logic [LEN_W-1:0]      len_q;
  logic                  started_q;
  logic                  err_pend_q;

  logic                  open_pkt;
  logic                  accept;
  logic                  abort;
  logic [OFS_W-1:0]      cur_ofs;
  logic [LEN_W-1:0]      cur_len;
  logic [CNT_W-1:0]      base_pos;
  logic [CMP_W-1:0]      ofs_ext;
  logic [CMP_W-1:0]      reg_end;
  logic [LB_W-1:0]       n_bytes;
  logic [SLICE_BYTES-1:0] keep;
  logic [7:0]            merged  [BUF_BYTES];
  logic [7:0]            shifted [BUF_BYTES];
  logic [FILL_W-1:0]     merge_cnt;
  logic [POS_W-1:0]      pos_sum;
  logic [CNT_W-1:0]      pos_next;
  logic                  region_err;
  logic                  started_cur;
  logic [DW-1:0]         head_data;
  logic [DW-1:0]         flush_data;
  state_t                open_state;

  // Keep mask, append of kept bytes behind the residue, and next-position bookkeeping.
  always_comb begin
    open_pkt = (state_q == PRE) || (state_q == SKIP) || (state_q == POST);
    accept   = i_valid && o_in_ready && (open_pkt || i_start);
    abort    = accept && i_start && open_pkt;
    cur_ofs  = i_start ? i_decap_ofs : ofs_q;
    cur_len  = i_start ? i_decap_len : len_q;
    base_pos = i_start ? '0 : pos_q;
    ofs_ext  = CMP_W'(cur_ofs);
    reg_end  = CMP_W'(cur_ofs) + CMP_W'(cur_len);
    n_bytes  = i_tail ? i_last_bytes : LB_W'(SLICE_BYTES);
    started_cur = i_start ? 1'b0 : started_q;

    for (int i = 0; i < SLICE_BYTES; i++) begin
      keep[i] = (LB_W'(i) < n_bytes) &&
                ((CMP_W'(base_pos) + CMP_W'(i) < ofs_ext) ||
                 (CMP_W'(base_pos) + CMP_W'(i) >= reg_end));
    end

    // A new start discards whatever an aborted packet left behind.
    for (int k = 0; k < BUF_BYTES; k++) begin
      merged[k] = i_start ? 8'h00 : pack_q[k];
    end
    merge_cnt = i_start ? '0 : fill_q;
    for (int i = 0; i < SLICE_BYTES; i++) begin
      if (keep[i]) begin
        merged[merge_cnt[IDX_W-1:0]] = i_data[DW-1-8*i -: 8];
        merge_cnt = merge_cnt + FILL_W'(1);
      end
    end

    for (int k = 0; k < SLICE_BYTES; k++) begin
      shifted[k] = merged[k+SLICE_BYTES];
    end
    for (int k = SLICE_BYTES; k < BUF_BYTES; k++) begin
      shifted[k] = 8'h00;
    end

    head_data  = '0;
    flush_data = '0;
    for (int j = 0; j < SLICE_BYTES; j++) begin
      head_data[DW-1-8*j -: 8]  = merged[j];
      flush_data[DW-1-8*j -: 8] = pack_q[j];
    end

    pos_sum    = POS_W'(base_pos) + POS_W'(n_bytes);
    pos_next   = (pos_sum > POS_W'(CNT_MAX)) ? CNT_MAX : pos_sum[CNT_W-1:0];
    region_err = reg_end > CMP_W'(pos_next);

    if (CMP_W'(pos_next) < ofs_ext) begin
      open_state = PRE;
    end else if (CMP_W'(pos_next) < reg_end) begin
      open_state = SKIP;
    end else begin
      open_state = POST;
    end
  end

  // Control FSM with registered outputs; buffer bytes at or beyond fill stay zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      for (int k = 0; k < BUF_BYTES; k++) pack_q[k] <= 8'h00;
      fill_q       <= '0;
      pos_q        <= '0;
      ofs_q        <= '0;
      len_q        <= '0;
      started_q    <= 1'b0;
      err_pend_q   <= 1'b0;
      o_in_ready   <= 1'b1;
      o_valid      <= 1'b0;
      o_start      <= 1'b0;
      o_tail       <= 1'b0;
      o_data       <= '0;
      o_last_bytes <= '0;
      o_err        <= 1'b0;
      o_drop       <= 1'b0;
    end else begin
      o_in_ready   <= 1'b1;
      o_valid      <= 1'b0;
      o_start      <= 1'b0;
      o_tail       <= 1'b0;
      o_data       <= '0;
      o_last_bytes <= '0;
      o_err        <= 1'b0;
      o_drop       <= 1'b0;

      if (state_q == FLUSH) begin
        o_valid      <= 1'b1;
        o_tail       <= 1'b1;
        o_start      <= !started_q;
        o_data       <= flush_data;
        o_last_bytes <= LB_W'(fill_q);
        o_err        <= err_pend_q;
        for (int k = 0; k < BUF_BYTES; k++) pack_q[k] <= 8'h00;
        fill_q       <= '0;
        started_q    <= 1'b0;
        err_pend_q   <= 1'b0;
        state_q      <= IDLE;
      end else if (accept) begin
        pos_q <= pos_next;
        ofs_q <= cur_ofs;
        len_q <= cur_len;
        o_err <= abort;
        if ((merge_cnt > FILL_W'(SLICE_BYTES)) ||
            (!i_tail && (merge_cnt == FILL_W'(SLICE_BYTES)))) begin
          o_valid      <= 1'b1;
          o_start      <= !started_cur;
          o_data       <= head_data;
          o_last_bytes <= LB_W'(SLICE_BYTES);
          pack_q       <= shifted;
          fill_q       <= merge_cnt - FILL_W'(SLICE_BYTES);
          started_q    <= 1'b1;
          if (i_tail) begin
            state_q    <= FLUSH;
            o_in_ready <= 1'b0;
            err_pend_q <= region_err;
          end else begin
            state_q    <= open_state;
          end
        end else if (!i_tail) begin
          pack_q    <= merged;
          fill_q    <= merge_cnt;
          started_q <= started_cur;
          state_q   <= open_state;
        end else begin
          // Tail fits in one slice; a packet that already emitted gets a zero-byte tail marker.
          o_err <= abort | region_err;
          if ((merge_cnt == '0) && !started_cur) begin
            o_drop <= 1'b1;
          end else begin
            o_valid      <= 1'b1;
            o_tail       <= 1'b1;
            o_start      <= !started_cur;
            o_data       <= head_data;
            o_last_bytes <= LB_W'(merge_cnt);
          end
          for (int k = 0; k < BUF_BYTES; k++) pack_q[k] <= 8'h00;
          fill_q    <= '0;
          started_q <= 1'b0;
          state_q   <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_decap_stream_shift.sv
// Randomised bench for decap_stream_shift: a byte-queue reference model predicts
// every output cycle, including ready, error and drop pulses.
module tb_decap_stream_shift;

  localparam int unsigned SB    = 16;
  localparam int unsigned DW    = SB * 8;
  localparam int unsigned LB_W  = $clog2(SB) + 1;
  localparam int unsigned BODY_W = DW + LB_W + 2;
  localparam int unsigned OBS_W = BODY_W + 4;

  logic            clk;
  logic            rst_n;
  logic            valid;
  logic            start;
  logic            tail;
  logic [DW-1:0]   data;
  logic [LB_W-1:0] last_bytes;
  logic [7:0]      decap_ofs;
  logic [7:0]      decap_len;
  logic            in_ready;
  logic            o_valid;
  logic            o_start;
  logic            o_tail;
  logic [DW-1:0]   o_data;
  logic [LB_W-1:0] o_last_bytes;
  logic            o_err;
  logic            o_drop;

  decap_stream_shift dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_start      (start),
    .i_tail       (tail),
    .i_data       (data),
    .i_last_bytes (last_bytes),
    .i_decap_ofs  (decap_ofs),
    .i_decap_len  (decap_len),
    .o_in_ready   (in_ready),
    .o_valid      (o_valid),
    .o_start      (o_start),
    .o_tail       (o_tail),
    .o_data       (o_data),
    .o_last_bytes (o_last_bytes),
    .o_err        (o_err),
    .o_drop       (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              rst;
    bit              v;
    bit              s;
    bit              t;
    logic [DW-1:0]   d;
    logic [LB_W-1:0] lb;
    logic [7:0]      ofs;
    logic [7:0]      len;
  } stim_t;

  stim_t       stim[$];
  logic [7:0]  q[$];
  bit          m_open, m_flush, m_started, m_err_pend, m_ready;
  int          m_pos, m_ofs, m_len;
  int          vecs, errs, cyc;

  task automatic push_idle(input bit stray);
    stim_t e;
    e.rst = 1'b0; e.v = stray; e.s = 1'b0; e.t = $urandom_range(0, 1) == 1;
    e.d = {$urandom, $urandom, $urandom, $urandom};
    e.lb = LB_W'($urandom_range(1, SB));
    e.ofs = 8'($urandom); e.len = 8'($urandom);
    stim.push_back(e);
  endtask

  task automatic push_rst(input int n);
    stim_t e;
    e.rst = 1'b1; e.v = 1'b0; e.s = 1'b0; e.t = 1'b0;
    e.d = '0; e.lb = '0; e.ofs = '0; e.len = '0;
    repeat (n) stim.push_back(e);
  endtask

  task automatic push_pkt(input int ofs, input int len, input int nbytes,
                          input int max_gap, input bit with_tail);
    stim_t e;
    int ns;
    ns = (nbytes + SB - 1) / SB;
    for (int k = 0; k < ns; k++) begin
      e.rst = 1'b0; e.v = 1'b1;
      e.s = (k == 0);
      e.t = with_tail && (k == ns - 1);
      e.d = {$urandom, $urandom, $urandom, $urandom};
      e.lb = e.t ? LB_W'(nbytes - SB * (ns - 1)) : LB_W'($urandom_range(1, SB));
      e.ofs = e.s ? 8'(ofs) : 8'($urandom);
      e.len = e.s ? 8'(len) : 8'($urandom);
      stim.push_back(e);
      if (k != ns - 1) repeat ($urandom_range(0, max_gap)) push_idle(1'b0);
    end
  endtask

  // Reference: keep rule applied per byte position, output slices popped from a byte queue.
  task automatic model_step(input stim_t e, output logic [OBS_W-1:0] ex, output bit consumed);
    bit ev, es, et, er, dr, rdy, abort, rerr;
    int elb, n, cnt;
    logic [DW-1:0] ed;
    ev = 0; es = 0; et = 0; er = 0; dr = 0; elb = 0; ed = '0; cnt = 0;
    consumed = !(e.v && !m_ready);
    if (e.rst) begin
      q.delete(); m_open = 0; m_flush = 0; m_started = 0; m_err_pend = 0; m_ready = 1;
      m_pos = 0; m_ofs = 0; m_len = 0; consumed = 1;
    end else if (m_flush) begin
      ev = 1; et = 1; es = !m_started; er = m_err_pend; cnt = q.size();
      m_flush = 0; m_ready = 1; m_err_pend = 0;
    end else if (e.v && (m_open || e.s)) begin
      abort = e.s && m_open;
      if (e.s) begin
        q.delete(); m_pos = 0; m_ofs = e.ofs; m_len = e.len; m_started = 0; m_open = 1;
      end
      n = e.t ? int'(e.lb) : SB;
      for (int i = 0; i < n; i++) begin
        if ((m_pos + i < m_ofs) || (m_pos + i >= m_ofs + m_len)) q.push_back(e.d[DW-1-8*i -: 8]);
      end
      m_pos = (m_pos + n > 4095) ? 4095 : m_pos + n;
      er = abort;
      if (e.t) begin
        m_open = 0;
        rerr = (m_ofs + m_len > m_pos);
        if (q.size() > SB) begin
          ev = 1; es = !m_started; cnt = SB;
          m_flush = 1; m_ready = 0; m_err_pend = rerr;
        end else begin
          er = abort | rerr;
          if (q.size() == 0 && !m_started) dr = 1;
          else begin ev = 1; et = 1; es = !m_started; cnt = q.size(); end
        end
      end else if (q.size() >= SB) begin
        ev = 1; es = !m_started; cnt = SB;
      end
    end
    if (ev) begin
      m_started = 1;
      elb = cnt;
      for (int j = 0; j < cnt; j++) ed[DW-1-8*j -: 8] = q.pop_front();
      if (et) q.delete();
    end
    rdy = m_ready;
    ex = {ev, (ev ? {es, et, LB_W'(elb), ed} : BODY_W'(0)), er, dr, rdy};
  endtask

  task automatic apply(input stim_t e, output logic [OBS_W-1:0] obs,
                       output logic [OBS_W-1:0] ex, output bit consumed);
    logic [BODY_W-1:0] body;
    rst_n = !e.rst; valid = e.v; start = e.s; tail = e.t; data = e.d;
    last_bytes = e.lb; decap_ofs = e.ofs; decap_len = e.len;
    model_step(e, ex, consumed);
    @(posedge clk);
    #1;
    body = ex[OBS_W-1] ? {o_start, o_tail, o_last_bytes, o_data} : BODY_W'(0);
    obs = {o_valid, body, o_err, o_drop, in_ready};
    cyc++;
  endtask

  task automatic test_reset();
    logic [OBS_W-1:0] obs, ex;
    bit took;
    push_rst(3);
    for (int k = 0; k < 1000 && stim.size() > 0; k++) begin
      apply(stim[0], obs, ex, took);
      if (took) void'(stim.pop_front());
      vecs++;
      if (obs !== ex) begin errs++; $display("FAIL reset cyc %0d: got %h want %h", cyc, obs, ex); end
    end
  endtask

  task automatic test_passthrough();
    logic [OBS_W-1:0] obs, ex;
    bit took;
    push_pkt(0, 0, 48, 0, 1'b1);
    push_idle(1'b0);
    push_pkt(0, 0, 37, 2, 1'b1);
    repeat (3) push_idle(1'b0);
    for (int k = 0; k < 1000 && stim.size() > 0; k++) begin
      apply(stim[0], obs, ex, took);
      if (took) void'(stim.pop_front());
      vecs++;
      if (obs !== ex) begin errs++; $display("FAIL passthrough cyc %0d: got %h want %h", cyc, obs, ex); end
    end
  endtask

  task automatic test_head_strip();
    logic [OBS_W-1:0] obs, ex;
    bit took;
    push_pkt(0, 14, 64, 0, 1'b1);
    push_pkt(0, 0, 16, 0, 1'b1);
    repeat (3) push_idle(1'b0);
    for (int k = 0; k < 1000 && stim.size() > 0; k++) begin
      apply(stim[0], obs, ex, took);
      if (took) void'(stim.pop_front());
      vecs++;
      if (obs !== ex) begin errs++; $display("FAIL head_strip cyc %0d: got %h want %h", cyc, obs, ex); end
    end
  endtask

  task automatic test_mid_region();
    logic [OBS_W-1:0] obs, ex;
    bit took;
    push_pkt(12, 20, 40, 0, 1'b1);
    repeat (3) push_idle(1'b0);
    push_pkt(5, 3, 8, 0, 1'b1);
    repeat (2) push_idle(1'b0);
    for (int k = 0; k < 1000 && stim.size() > 0; k++) begin
      apply(stim[0], obs, ex, took);
      if (took) void'(stim.pop_front());
      vecs++;
      if (obs !== ex) begin errs++; $display("FAIL mid_region cyc %0d: got %h want %h", cyc, obs, ex); end
    end
  endtask

  task automatic test_overrun();
    logic [OBS_W-1:0] obs, ex;
    bit took;
    push_pkt(30, 40, 48, 0, 1'b1);
    repeat (2) push_idle(1'b0);
    push_pkt(2, 255, 60, 1, 1'b1);
    repeat (3) push_idle(1'b0);
    for (int k = 0; k < 1000 && stim.size() > 0; k++) begin
      apply(stim[0], obs, ex, took);
      if (took) void'(stim.pop_front());
      vecs++;
      if (obs !== ex) begin errs++; $display("FAIL overrun cyc %0d: got %h want %h", cyc, obs, ex); end
    end
  endtask

  task automatic test_drop_back_to_back();
    logic [OBS_W-1:0] obs, ex;
    bit took;
    push_pkt(0, 32, 32, 0, 1'b1);
    push_pkt(0, 0, 40, 0, 1'b1);
    repeat (3) push_idle(1'b0);
    for (int k = 0; k < 1000 && stim.size() > 0; k++) begin
      apply(stim[0], obs, ex, took);
      if (took) void'(stim.pop_front());
      vecs++;
      if (obs !== ex) begin errs++; $display("FAIL drop_b2b cyc %0d: got %h want %h", cyc, obs, ex); end
    end
  endtask

  task automatic test_abort_reset();
    logic [OBS_W-1:0] obs, ex;
    bit took;
    push_pkt(3, 5, 32, 0, 1'b0);
    push_pkt(4, 6, 40, 0, 1'b1);
    repeat (2) push_idle(1'b0);
    push_pkt(0, 0, 40, 0, 1'b0);
    push_rst(2);
    repeat (4) push_idle(1'b1);
    push_pkt(1, 1, 20, 0, 1'b1);
    repeat (3) push_idle(1'b0);
    for (int k = 0; k < 1000 && stim.size() > 0; k++) begin
      apply(stim[0], obs, ex, took);
      if (took) void'(stim.pop_front());
      vecs++;
      if (obs !== ex) begin errs++; $display("FAIL abort_reset cyc %0d: got %h want %h", cyc, obs, ex); end
    end
  endtask

  task automatic test_random();
    logic [OBS_W-1:0] obs, ex;
    bit took;
    int ofs, len;
    for (int p = 0; p < 60; p++) begin
      ofs = $urandom_range(0, 70);
      case ($urandom_range(0, 3))
        0:       len = 0;
        1:       len = 255;
        default: len = $urandom_range(0, 60);
      endcase
      if ($urandom_range(0, 7) == 0) push_pkt(ofs, len, $urandom_range(16, 64), 1, 1'b0);
      else begin
        push_pkt(ofs, len, $urandom_range(1, 96), 2, 1'b1);
        repeat ($urandom_range(0, 2)) push_idle($urandom_range(0, 3) == 0);
      end
    end
    push_pkt(0, 0, 16, 0, 1'b1);
    repeat (3) push_idle(1'b0);
    for (int k = 0; k < 20000 && stim.size() > 0; k++) begin
      apply(stim[0], obs, ex, took);
      if (took) void'(stim.pop_front());
      vecs++;
      if (obs !== ex) begin errs++; $display("FAIL random cyc %0d: got %h want %h", cyc, obs, ex); end
    end
  endtask

  initial begin
    vecs = 0; errs = 0; cyc = 0;
    rst_n = 1'b0; valid = 1'b0; start = 1'b0; tail = 1'b0; data = '0;
    last_bytes = '0; decap_ofs = '0; decap_len = '0;
    m_ready = 1'b1; m_open = 1'b0; m_flush = 1'b0; m_started = 1'b0; m_err_pend = 1'b0;
    m_pos = 0; m_ofs = 0; m_len = 0;
    test_reset();
    test_passthrough();
    test_head_strip();
    test_mid_region();
    test_overrun();
    test_drop_back_to_back();
    test_abort_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
